data_ram_arbiter: RTL

Two-master arbiter that shares the single-port data RAM of the minimal SOPC between the CPU data port (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits between the masters and `data_ram`. It registers a grant, forwards the granted master's request to the RAM, and returns read data and a per-access acknowledge. Under contention it rotates ownership round-robin, with a bounded burst length, and raises a stall toward the CPU pipeline controller while master 0 waits.

---
 rtl/data_ram_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data RAM.
// Grant is registered; request forwarding, ack and read-data return are combinational.
module data_ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_ce,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_stall_o,
    input  logic              m1_ce,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);
    localparam int NUM_M = 2;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef struct packed {
        logic              ce;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        sel;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    req_t [NUM_M-1:0]             req;
    logic [NUM_M-1:0]             gnt;
    logic [NUM_M-1:0]             ack;
    logic [NUM_M-1:0][DATA_W-1:0] rdata;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic             own_idx;
    logic             own_ce;
    logic             oth_ce;

    assign req[0] = {m0_ce, m0_we, m0_addr, m0_sel, m0_wdata};
    assign req[1] = {m1_ce, m1_we, m1_addr, m1_sel, m1_wdata};

    assign own_idx = (state == GNT1);
    assign own_ce  = req[own_idx].ce;
    assign oth_ce  = req[~own_idx].ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (req[0].ce && req[1].ce) state_nxt = last_grant ? GNT0 : GNT1;
                else if (req[0].ce)         state_nxt = GNT0;
                else if (req[1].ce)         state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                // Handover goes straight to the other grant state, no IDLE bubble.
                if (oth_ce && (!own_ce || burst_cnt == CNT_LAST)) begin
                    state_nxt      = own_idx ? GNT0 : GNT1;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = own_idx;
                end else if (!own_ce && !oth_ce) begin
                    state_nxt      = IDLE;
                    burst_cnt_nxt  = '0;
                    last_grant_nxt = own_idx;
                end else if (!oth_ce) begin
                    burst_cnt_nxt = '0;
                end else if (burst_cnt != CNT_LAST) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_sel    = '0;
        ram_data_o = '0;
        case (state)
            GNT0, GNT1: begin
                gnt[own_idx] = 1'b1;
                ram_ce       = req[own_idx].ce;
                ram_we       = req[own_idx].we;
                ram_addr     = req[own_idx].addr;
                ram_sel      = req[own_idx].sel;
                ram_data_o   = req[own_idx].wdata;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_M; i++) begin : g_port
        data_ram_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .gnt       (gnt[i]),
            .ce        (req[i].ce),
            .ram_rdata (ram_data_i),
            .ack       (ack[i]),
            .rdata     (rdata[i])
        );
    end

    assign m0_ack   = ack[0];
    assign m1_ack   = ack[1];
    assign m0_rdata = rdata[0];
    assign m1_rdata = rdata[1];

    // Held low during reset so every output reads 0 even if the CPU keeps ce asserted.
    assign m0_stall_o = m0_ce & ~m0_ack & ~rst;

    a_one_ack: assert property (@(posedge clk) disable iff (rst) !(m0_ack && m1_ack));

endmodule

// Per-master return path: ack and read data only reach the granted master.
module data_ram_arbiter_port #(
    parameter int DATA_W = 32
) (
    input  logic              gnt,
    input  logic              ce,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);
    assign ack   = gnt & ce;
    assign rdata = gnt ? ram_rdata : '0;
endmodule
